// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic family (adder, subtractor).
// Holds the default operand width and the common three-state FSM encoding.
package serial_arith_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   // Encoding 2'd3 is unused; the FSMs treat it as illegal and recover to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder used as the serial bit cell.
// Ports: a, b, cin  - addend bits and carry-in
//        sum_c      - a ^ b ^ cin
//        cout_c     - majority(a, b, cin)
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum_c,
   output logic cout_c
);

   assign sum_c  = a ^ b ^ cin;
   assign cout_c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: {cout, sum_out} = a_in + b_in + cin, one bit per clock,
// LSB first, through a single registered carry.
// Ports: clk, rst_n                 - clock, async active-low reset
//        start_valid/start_ready    - operand handshake (a_in, b_in, cin)
//        sum_out, cout              - registered result, held until next accept
//        done_valid/done_ready      - result handshake
//        busy                       - high in SHIFT or DONE
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout,
   output logic             done_valid,
   input  logic             done_ready,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               bit_sum;
   logic               bit_carry;

   // Bit cell; the carry register lives here, outside the cell.
   full_adder u_fa (
      .a      (a_q[0]),
      .b      (b_q[0]),
      .cin    (carry_q),
      .sum_c  (bit_sum),
      .cout_c (bit_carry)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               carry_d = cin;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            carry_d = bit_carry;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            sum_d   = {bit_sum, sum_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cout_d  = bit_carry;
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (done_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status outputs are pure decodes of the state register.
   assign start_ready = (state_q == ST_IDLE);
   assign done_valid  = (state_q == ST_DONE);
   assign busy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign sum_out     = sum_q;
   assign cout        = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the scenario tests and
// a 4-bit instance swept over all operand/carry combinations.
module tb_serial_adder;

   localparam int unsigned W  = 8;
   localparam int unsigned W4 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          start_valid, start_ready;
   logic [W-1:0]  a_in, b_in, sum_out;
   logic          cin, cout, done_valid, done_ready, busy;

   logic          start_valid4, start_ready4;
   logic [W4-1:0] a4, b4, sum4;
   logic          cin4, cout4, done_valid4, busy4;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   serial_adder #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a_in        (a_in),
      .b_in        (b_in),
      .cin         (cin),
      .sum_out     (sum_out),
      .cout        (cout),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .busy        (busy)
   );

   serial_adder #(.WIDTH(W4)) dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid4),
      .start_ready (start_ready4),
      .a_in        (a4),
      .b_in        (b4),
      .cin         (cin4),
      .sum_out     (sum4),
      .cout        (cout4),
      .done_valid  (done_valid4),
      .done_ready  (1'b1),
      .busy        (busy4)
   );

   // Present operands at a falling edge and hold them across one accepting edge.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int t;
      t = 0;
      @(negedge clk);
      while (!start_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      start_valid = 1'b1;
      a_in = a;
      b_in = b;
      cin  = c;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
   endtask

   // Called at a falling edge after accept; lat = rising edges until done_valid, -1 on timeout.
   task automatic wait_done(output int lat);
      int n;
      n = 0;
      while (!done_valid && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      lat = done_valid ? n : -1;
   endtask

   task automatic release_done();
      done_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      done_ready = 1'b0;
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] s, output logic co, output int lat);
      accept(a, b, c);
      wait_done(lat);
      s  = sum_out;
      co = cout;
      release_done();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_valid = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; done_ready = 1'b0;
      start_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({start_ready, done_valid, busy} !== 3'b100) begin
         fails++;
         $display("FAIL reset_status got rdy/dv/busy=%b want 100", {start_ready, done_valid, busy});
      end
      tests++;
      if ({cout, sum_out} !== 9'h000) begin
         fails++;
         $display("FAIL reset_result got cout/sum=%h want 000", {cout, sum_out});
      end
   endtask

   task automatic test_basic();
      int  n;
      logic busy_ok;
      accept(8'h05, 8'h03, 1'b0);
      n = 0;
      busy_ok = busy;
      while (!done_valid && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         busy_ok = busy_ok & busy;
      end
      tests++;
      if (n !== 8) begin
         fails++;
         $display("FAIL basic_latency got %0d edges want 8", n);
      end
      tests++;
      if (busy_ok !== 1'b1) begin
         fails++;
         $display("FAIL basic_busy got busy low during SHIFT/DONE want high");
      end
      tests++;
      if ({cout, sum_out} !== 9'h008) begin
         fails++;
         $display("FAIL basic_sum got cout/sum=%h want 008", {cout, sum_out});
      end
      release_done();
      tests++;
      if ({start_ready, done_valid, busy} !== 3'b100) begin
         fails++;
         $display("FAIL basic_handoff got rdy/dv/busy=%b want 100", {start_ready, done_valid, busy});
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] s;
      logic co;
      int lat;
      do_op(8'hFF, 8'h01, 1'b0, s, co, lat);
      tests++;
      if ({co, s} !== 9'h100) begin
         fails++;
         $display("FAIL ovf_ff_01 got cout/sum=%h want 100", {co, s});
      end
      do_op(8'hFF, 8'hFF, 1'b1, s, co, lat);
      tests++;
      if ({co, s} !== 9'h1FF) begin
         fails++;
         $display("FAIL ovf_ff_ff_c got cout/sum=%h want 1ff", {co, s});
      end
   endtask

   task automatic test_stall();
      int lat;
      int bad;
      logic [W-1:0] s;
      logic co;
      accept(8'h12, 8'h34, 1'b0);
      wait_done(lat);
      start_valid = 1'b1;
      a_in = 8'h77;
      b_in = 8'h11;
      cin  = 1'b0;
      bad  = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         if ({cout, sum_out} !== 9'h046 || start_ready !== 1'b0 || done_valid !== 1'b1
             || busy !== 1'b1)
            bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL stall_hold got %0d bad cycles (cout/sum=%h rdy=%b) want 0 (046)",
                  bad, {cout, sum_out}, start_ready);
      end
      done_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      done_ready = 1'b0;
      tests++;
      if ({start_ready, done_valid} !== 2'b10) begin
         fails++;
         $display("FAIL stall_release got rdy/dv=%b want 10", {start_ready, done_valid});
      end
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      wait_done(lat);
      s  = sum_out;
      co = cout;
      release_done();
      tests++;
      if ({co, s} !== 9'h088 || lat !== 8) begin
         fails++;
         $display("FAIL stall_next got cout/sum=%h lat=%0d want 088 lat=8", {co, s}, lat);
      end
   endtask

   task automatic test_input_change();
      int lat;
      accept(8'h3C, 8'h0F, 1'b0);
      a_in = 8'hAA;
      b_in = 8'h55;
      cin  = 1'b1;
      wait_done(lat);
      tests++;
      if ({cout, sum_out} !== 9'h04B) begin
         fails++;
         $display("FAIL input_change got cout/sum=%h want 04b", {cout, sum_out});
      end
      release_done();
   endtask

   task automatic test_midreset();
      logic [W-1:0] s;
      logic co;
      int lat;
      accept(8'h80, 8'h80, 1'b0);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL midreset_pre got busy=%b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({done_valid, busy, cout, sum_out} !== 11'h000) begin
         fails++;
         $display("FAIL midreset_clear got dv/busy/cout/sum=%h want 000",
                  {done_valid, busy, cout, sum_out});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (start_ready !== 1'b1) begin
         fails++;
         $display("FAIL midreset_ready got %b want 1", start_ready);
      end
      do_op(8'h80, 8'h80, 1'b0, s, co, lat);
      tests++;
      if ({co, s} !== 9'h100) begin
         fails++;
         $display("FAIL midreset_rerun got cout/sum=%h want 100", {co, s});
      end
   endtask

   task automatic test_exhaustive4();
      int t;
      int acc_cyc;
      int prev_cyc;
      logic [W4:0] exp;
      prev_cyc = -1;
      start_valid4 = 1'b1;
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         a4   = W4'(i >> 5);
         b4   = W4'(i >> 1);
         cin4 = i[0];
         exp  = (W4+1)'(a4) + (W4+1)'(b4) + (W4+1)'(cin4);
         t = 0;
         while (!start_ready4 && t < 20) begin
            @(negedge clk);
            t++;
         end
         @(posedge clk);
         @(negedge clk);
         acc_cyc = cyc;
         t = 0;
         while (!done_valid4 && t < 20) begin
            @(negedge clk);
            t++;
         end
         tests++;
         if ({cout4, sum4} !== exp || done_valid4 !== 1'b1) begin
            fails++;
            $display("FAIL exh4_sum a=%h b=%h c=%b got dv=%b cout/sum=%h want %h",
                     a4, b4, cin4, done_valid4, {cout4, sum4}, exp);
         end
         if (prev_cyc >= 0) begin
            tests++;
            if (acc_cyc - prev_cyc !== int'(W4 + 2)) begin
               fails++;
               $display("FAIL exh4_ii got %0d cycles want %0d", acc_cyc - prev_cyc, W4 + 2);
            end
         end
         prev_cyc = acc_cyc;
      end
      start_valid4 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_stall();
      test_input_change();
      test_midreset();
      test_exhaustive4();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
